texture_tiler: RTL and testbench
================================

Name: texture_tiler

Overview:
- Pixel-fetch stage directly upstream of the 32x32 RGB565 texture ROM (1024x16 Gowin pROM, 1-cycle synchronous read).
- Maps VGA beam position (hpos/vpos) to a tiled texture address with per-frame scroll offsets and drives the ROM address and enables.
- Consumes ROM dout, splits it into R/G/B and blanks it outside the active area.
- Re-times hsync/vsync/de so pixel data and sync arrive at the VGA output pins aligned.

Parameters:
- TEX_LOG2, 5: log2 of texture edge; address = {v, u}, 2*TEX_LOG2 bits.
- SCROLL_STEP, 1: offset increment per frame tick, in texels.
- HSYNC_ACTIVE, 0: active level of hsync_in/hsync_out.
- VSYNC_ACTIVE, 0: active level of vsync_in/vsync_out.

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- hpos  in  10  beam column
- vpos  in  10  beam row
- de_in  in  1  active-video flag
- hsync_in  in  1  horizontal sync from the timing generator
- vsync_in  in  1  vertical sync from the timing generator
- scroll_en  in  1  enables the scroll FSM
- rom_ad  out  10  texture ROM address
- rom_ce  out  1  ROM clock enable
- rom_oce  out  1  ROM output clock enable (tied 1)
- rom_reset  out  1  ROM sync reset, equals ~reset_n
- rom_dout  in  16  ROM data, RGB565
- r  out  5  red
- g  out  6  green
- b  out  5  blue
- de_out  out  1  delayed de
- hsync_out  out  1  delayed hsync
- vsync_out  out  1  delayed vsync

Behaviour:
- One clock. reset_n is asynchronous and active-low.
- Reset values:
  - rom_ad = 0, rom_ce = 0, r/g/b = 0, de_out = 0.
  - hsync_out = ~HSYNC_ACTIVE, vsync_out = ~VSYNC_ACTIVE.
  - Offsets x_off = y_off = 0, frame_cnt = 0, FSM = RIGHT.
  - Internal pipeline registers clear to the inactive/zero levels above.
- Stage 1 (edge k):
  - u = (hpos + x_off) mod 32, v = (vpos + y_off) mod 32.
  - rom_ad <= {v, u}; rom_ce <= de_in; sync/de delayed by 1 register.
- Stage 2 (edge k+1): ROM registers dout; sync/de delayed by a 2nd register.
- Stage 3 (edge k+2):
  - {r, g, b} <= rom_dout[15:11], [10:5], [4:0] when delayed de = 1, else 0.
  - Sync/de delayed by a 3rd register.
- Fixed latency is 3 clocks from input to output for data, de and syncs alike.
- Frame tick: a 1-cycle pulse on the clock where vsync_in goes from inactive to active (edge detect on the registered previous value). Offsets change only on the tick, so there is no mid-frame tearing.
- Scroll FSM states: RIGHT, DOWN, LEFT, UP.
  - On a tick with scroll_en = 1:
    - RIGHT: x_off += SCROLL_STEP.
    - DOWN: y_off += SCROLL_STEP.
    - LEFT: x_off -= SCROLL_STEP.
    - UP: y_off -= SCROLL_STEP.
    - frame_cnt increments.
  - When frame_cnt = 31 at a tick, frame_cnt wraps to 0 and the state advances RIGHT→DOWN→LEFT→UP→RIGHT.
  - With scroll_en = 0 on the tick: offsets, frame_cnt and state all hold.
- Arithmetic:
  - Offsets are 5 bits and wrap modulo 32.
  - hpos + x_off is computed 11 bits wide; only the low 5 bits address the ROM, and bit 5 is the tile-parity bit.
- Boundaries:
  - hpos ≥ 640 or vpos ≥ 480 is don't-care for the address; blanking comes only from de.
  - scroll_en toggling in the same cycle as the tick: the value sampled at that edge decides.
  - Reset mid-frame clears the pipeline. Outputs stay blank with inactive syncs until valid inputs propagate, 3 cycles after reset release.

Optional Feature:
- Macro: TEXTURE_TILER_MIRROR_EN.
- Defined:
  - Odd tile columns (bit 5 of hpos + x_off = 1) use u' = 31 − u.
  - Odd tile rows use v' = 31 − v.
  - The result is seamless mirrored tiling; latency is unchanged.
- Undefined: plain repeat tiling; the parity logic is not synthesized.

Test Plan:
- Reset: hold reset_n = 0 with random inputs → rom_ad = 0, r = g = b = 0, de_out = 0, hsync_out = vsync_out = 1.
- Latency: hpos = 3, vpos = 2, de_in = 1, offsets 0 → rom_ad = 0x043 after 1 clock. ROM model returns 0x3B07 → r = 0x07, g = 0x18, b = 0x07 with de_out = 1 exactly 3 clocks after the input.
- Wrap: hpos = 37, vpos = 33 → rom_ad = 0x025.
- Blanking: de_in = 0, rom_dout = 0xFFFF → r = g = b = 0; hsync_in pulse reappears on hsync_out 3 clocks later with width unchanged.
- Scroll: scroll_en = 1, one vsync tick → x_off = 1, and hpos = 31, vpos = 0 gives rom_ad = 0x000. After 32 ticks: state = DOWN, x_off = 0. Tick 33 → y_off = 1. With scroll_en = 0 over 10 ticks → offsets unchanged.
- Mirror (macro defined): hpos = 32, vpos = 0, offsets 0 → rom_ad = 0x01F; hpos = 0, vpos = 32 → rom_ad = 0x3E0.

Source files
------------

// File: rtl/texture_tiler.sv
// texture_tiler: maps the VGA beam position onto a scrolling, tiled 32x32 RGB565 texture ROM.
// Define TEXTURE_TILER_MIRROR_EN to mirror odd tile rows and columns for seamless tiling.
module texture_tiler #(
    parameter int   TEX_LOG2     = 5,
    parameter int   SCROLL_STEP  = 1,
    parameter logic HSYNC_ACTIVE = 1'b0,
    parameter logic VSYNC_ACTIVE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [9:0]            hpos,
    input  logic [9:0]            vpos,
    input  logic                  de_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  scroll_en,
    output logic [2*TEX_LOG2-1:0] rom_ad,
    output logic                  rom_ce,
    output logic                  rom_oce,
    output logic                  rom_reset,
    input  logic [15:0]           rom_dout,
    output logic [4:0]            r,
    output logic [5:0]            g,
    output logic [4:0]            b,
    output logic                  de_out,
    output logic                  hsync_out,
    output logic                  vsync_out
);

    typedef enum logic [1:0] {S_RIGHT, S_DOWN, S_LEFT, S_UP} scroll_state_t;

    localparam logic [TEX_LOG2-1:0] STEP = TEX_LOG2'(SCROLL_STEP);

    scroll_state_t       r_state;
    scroll_state_t       w_next_state;
    logic [TEX_LOG2-1:0] r_x_off;
    logic [TEX_LOG2-1:0] r_y_off;
    logic [4:0]          r_frame_cnt;
    logic                r_vsync_prev;
    logic                w_tick;

    logic [10:0]         w_hsum;
    logic [10:0]         w_vsum;
    logic [TEX_LOG2-1:0] w_u;
    logic [TEX_LOG2-1:0] w_v;
    logic                w_unused;

    logic r_de1, r_de2;
    logic r_hs1, r_hs2;
    logic r_vs1, r_vs2;

    assign rom_oce   = 1'b1;
    assign rom_reset = ~reset_n;

    // Bits above the texture index carry only tile position; just the parity bit matters.
    assign w_hsum = {1'b0, hpos} + 11'(r_x_off);
    assign w_vsum = {1'b0, vpos} + 11'(r_y_off);

`ifdef TEXTURE_TILER_MIRROR_EN
    // 31 - u is the bitwise complement of a 5-bit index.
    assign w_u = w_hsum[TEX_LOG2] ? ~w_hsum[TEX_LOG2-1:0] : w_hsum[TEX_LOG2-1:0];
    assign w_v = w_vsum[TEX_LOG2] ? ~w_vsum[TEX_LOG2-1:0] : w_vsum[TEX_LOG2-1:0];
`else
    assign w_u = w_hsum[TEX_LOG2-1:0];
    assign w_v = w_vsum[TEX_LOG2-1:0];
`endif

    assign w_unused = ^{w_hsum[10:TEX_LOG2], w_vsum[10:TEX_LOG2]};

    assign w_tick = (vsync_in == VSYNC_ACTIVE) && (r_vsync_prev != VSYNC_ACTIVE);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RIGHT: w_next_state = S_DOWN;
            S_DOWN:  w_next_state = S_LEFT;
            S_LEFT:  w_next_state = S_UP;
            default: w_next_state = S_RIGHT;
        endcase
    end

    // Offsets move only on the frame tick so a frame is never drawn with two offsets.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_RIGHT;
            r_x_off     <= '0;
            r_y_off     <= '0;
            r_frame_cnt <= '0;
        end else if (w_tick && scroll_en) begin
            case (r_state)
                S_RIGHT: r_x_off <= r_x_off + STEP;
                S_DOWN:  r_y_off <= r_y_off + STEP;
                S_LEFT:  r_x_off <= r_x_off - STEP;
                default: r_y_off <= r_y_off - STEP;
            endcase
            if (r_frame_cnt == 5'd31) begin
                r_frame_cnt <= '0;
                r_state     <= w_next_state;
            end else begin
                r_frame_cnt <= r_frame_cnt + 5'd1;
            end
        end
    end

    // NOTE: every register here uses <= so all stages sample pre-edge values; blocking
    // assignments would collapse the three-stage delay into fewer cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vsync_prev <= ~VSYNC_ACTIVE;
            rom_ad       <= '0;
            rom_ce       <= 1'b0;
            r_de1        <= 1'b0;
            r_de2        <= 1'b0;
            r_hs1        <= ~HSYNC_ACTIVE;
            r_hs2        <= ~HSYNC_ACTIVE;
            r_vs1        <= ~VSYNC_ACTIVE;
            r_vs2        <= ~VSYNC_ACTIVE;
            r            <= '0;
            g            <= '0;
            b            <= '0;
            de_out       <= 1'b0;
            hsync_out    <= ~HSYNC_ACTIVE;
            vsync_out    <= ~VSYNC_ACTIVE;
        end else begin
            r_vsync_prev <= vsync_in;

            rom_ad <= {w_v, w_u};
            rom_ce <= de_in;
            r_de1  <= de_in;
            r_hs1  <= hsync_in;
            r_vs1  <= vsync_in;

            // The ROM registers its data on this edge; only the timing signals need holding.
            r_de2 <= r_de1;
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;

            r         <= r_de2 ? rom_dout[15:11] : 5'd0;
            g         <= r_de2 ? rom_dout[10:5]  : 6'd0;
            b         <= r_de2 ? rom_dout[4:0]   : 5'd0;
            de_out    <= r_de2;
            hsync_out <= r_hs2;
            vsync_out <= r_vs2;
        end
    end

endmodule

// File: tb/tb_texture_tiler.sv
// tb_texture_tiler: randomized scoreboard bench for texture_tiler with a 1-cycle ROM model.
// A driver pushes expected responses; an independent negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_texture_tiler;

    localparam logic HS_ACT   = 1'b0;
    localparam logic VS_ACT   = 1'b0;
    localparam logic HS_INACT = 1'b1;
    localparam logic VS_INACT = 1'b1;
    localparam int   STEP     = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  hpos = '0, vpos = '0;
    logic        de_in = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1, scroll_en = 1'b0;
    logic [9:0]  rom_ad;
    logic        rom_ce, rom_oce, rom_reset;
    logic [15:0] rom_dout;
    logic [4:0]  r, b;
    logic [5:0]  g;
    logic        de_out, hsync_out, vsync_out;

    always #5 clk = ~clk;

    texture_tiler dut (
        .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .scroll_en(scroll_en),
        .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_reset(rom_reset),
        .rom_dout(rom_dout), .r(r), .g(g), .b(b), .de_out(de_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    // Texture ROM model: synchronous read, optional forced all-ones data bus.
    logic [15:0] mem [1024];
    logic [15:0] rom_q = '0;
    logic        force_ffff = 1'b0;
    always @(posedge clk) begin
        if (rom_reset)             rom_q <= 16'h0000;
        else if (rom_ce && rom_oce) rom_q <= mem[rom_ad];
    end
    assign rom_dout = force_ffff ? 16'hFFFF : rom_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; logic [9:0] ad; logic ce; } ad_exp_t;
    typedef struct { int due; logic [15:0] rgb; logic de; logic hs; logic vs; } out_exp_t;
    ad_exp_t  ad_q[$];
    out_exp_t out_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    // Reference model: offsets as integers, direction derived from the count of enabled ticks.
    int   m_x, m_y, m_n;
    logic m_vs_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (ad_q.size() > 0 && ad_q[0].due == cyc) begin
                ad_exp_t e;
                e = ad_q.pop_front();
                check("rom_ad", 32'(rom_ad), 32'(e.ad));
                check("rom_ce", 32'(rom_ce), 32'(e.ce));
            end
            while (out_q.size() > 0 && out_q[0].due == cyc) begin
                out_exp_t e;
                e = out_q.pop_front();
                check("rgb", 32'({r, g, b}), 32'(e.rgb));
                check("de_hs_vs", 32'({de_out, hsync_out, vsync_out}), 32'({e.de, e.hs, e.vs}));
            end
        end
    end

    int  hs_width = 0;
    bit  hs_cnt_en = 1'b0;
    always @(negedge clk) if (hs_cnt_en && hsync_out == HS_ACT) hs_width++;

    function automatic int wrap32(input int x);
        return ((x % 32) + 32) % 32;
    endfunction

    task automatic model_tick();
        case ((m_n / 32) % 4)
            0:       m_x = wrap32(m_x + STEP);
            1:       m_y = wrap32(m_y + STEP);
            2:       m_x = wrap32(m_x - STEP);
            default: m_y = wrap32(m_y - STEP);
        endcase
        m_n++;
    endtask

    task automatic step(input logic [9:0] h, input logic [9:0] v, input logic de,
                        input logic hs, input logic vs, input logic en);
        int hsum, vsum, u, w;
        logic [9:0] a;
        @(negedge clk);
        hpos = h; vpos = v; de_in = de; hsync_in = hs; vsync_in = vs; scroll_en = en;
        hsum = int'(h) + m_x;
        vsum = int'(v) + m_y;
        u = hsum % 32;
        w = vsum % 32;
`ifdef TEXTURE_TILER_MIRROR_EN
        if ((hsum / 32) % 2 == 1) u = 31 - u;
        if ((vsum / 32) % 2 == 1) w = 31 - w;
`endif
        a = 10'(w * 32 + u);
        ad_q.push_back('{due: cyc + 1, ad: a, ce: de});
        out_q.push_back('{due: cyc + 3, rgb: (de ? mem[a] : 16'h0000), de: de, hs: hs, vs: vs});
        if (vs == VS_ACT && m_vs_prev != VS_ACT && en) model_tick();
        m_vs_prev = vs;
    endtask

    task automatic idle();
        step(10'd0, 10'd0, 1'b0, HS_INACT, VS_INACT, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_ad"}, 32'(rom_ad), 32'h0);
        check({tag, "_rom_ce"}, 32'(rom_ce), 32'h0);
        check({tag, "_rgb"}, 32'({r, g, b}), 32'h0);
        check({tag, "_de_hs_vs"}, 32'({de_out, hsync_out, vsync_out}), 32'({1'b0, HS_INACT, VS_INACT}));
        check({tag, "_rom_rst_oce"}, 32'({rom_reset, rom_oce}), 32'b11);
    endtask

    // Asserts reset between clock edges, holds it under random inputs, releases with idle inputs.
    task automatic do_reset();
        @(posedge clk);
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        ad_q.delete();
        out_q.delete();
        m_x = 0; m_y = 0; m_n = 0; m_vs_prev = VS_INACT;
        #1 check_reset_outputs("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            hpos = 10'($urandom); vpos = 10'($urandom);
            de_in = 1'($urandom); hsync_in = 1'($urandom);
            vsync_in = 1'($urandom); scroll_en = 1'($urandom);
            check_reset_outputs("rst_hold");
        end
        @(negedge clk);
        reset_n = 1'b1;
        hpos = '0; vpos = '0; de_in = 1'b0; hsync_in = HS_INACT; vsync_in = VS_INACT; scroll_en = 1'b0;
        ad_q.push_back('{due: cyc + 1, ad: 10'h000, ce: 1'b0});
        for (int i = 1; i <= 3; i++)
            out_q.push_back('{due: cyc + i, rgb: 16'h0000, de: 1'b0, hs: HS_INACT, vs: VS_INACT});
        mon_en = 1'b1;
    endtask

    // Short directed frame: two idle lines then a two-cycle vsync pulse (tick on the first).
    task automatic short_frame(input logic en);
        idle();
        idle();
        step(10'd0, 10'd0, 1'b0, HS_INACT, VS_ACT, en);
        step(10'd0, 10'd0, 1'b0, HS_INACT, VS_ACT, en);
    endtask

    task automatic random_frame();
        logic en;
        en = 1'($urandom);
        for (int i = 0; i < 12; i++)
            step(10'($urandom_range(639, 0)), 10'($urandom_range(479, 0)),
                 1'($urandom), 1'($urandom), VS_INACT, 1'($urandom));
        // The scroll_en value on the tick cycle itself is what counts.
        step(10'($urandom_range(639, 0)), 10'($urandom_range(479, 0)), 1'b0, 1'($urandom), VS_ACT, en);
        step(10'($urandom_range(639, 0)), 10'($urandom_range(479, 0)), 1'b0, 1'($urandom), VS_ACT, ~en);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[10'h043] = 16'h3B07;
        mem[10'h0E5] = 16'hA5C3;

        do_reset();

        // Latency: address after one clock, pixel and de three clocks after the input.
        step(10'd3, 10'd2, 1'b1, HS_INACT, VS_INACT, 1'b0);
        idle();
        check("lat_rom_ad", 32'(rom_ad), 32'h043);
        idle();
        idle();
        check("lat_rgb", 32'({r, g, b}), 32'({5'h07, 6'h18, 5'h07}));
        check("lat_de", 32'(de_out), 32'h1);

`ifndef TEXTURE_TILER_MIRROR_EN
        step(10'd37, 10'd33, 1'b1, HS_INACT, VS_INACT, 1'b0);
        idle();
        check("wrap_rom_ad", 32'(rom_ad), 32'h025);
`else
        step(10'd32, 10'd0, 1'b1, HS_INACT, VS_INACT, 1'b0);
        idle();
        check("mirror_u_rom_ad", 32'(rom_ad), 32'h01F);
        step(10'd0, 10'd32, 1'b1, HS_INACT, VS_INACT, 1'b0);
        idle();
        check("mirror_v_rom_ad", 32'(rom_ad), 32'h3E0);
`endif

        // Blanking with an all-ones data bus and a 5-cycle hsync pulse.
        repeat (3) idle();
        force_ffff = 1'b1;
        hs_width   = 0;
        hs_cnt_en  = 1'b1;
        for (int i = 0; i < 12; i++)
            step(10'($urandom_range(639, 0)), 10'($urandom_range(479, 0)), 1'b0,
                 (i >= 2 && i <= 6) ? HS_ACT : HS_INACT, VS_INACT, 1'b0);
        repeat (4) idle();
        hs_cnt_en  = 1'b0;
        force_ffff = 1'b0;
        check("hsync_width", 32'(hs_width), 32'd5);

        // Scroll: one tick moves x by one texel.
        short_frame(1'b1);
        step(10'd31, 10'd0, 1'b1, HS_INACT, VS_INACT, 1'b0);
        idle();
`ifndef TEXTURE_TILER_MIRROR_EN
        check("scroll1_rom_ad", 32'(rom_ad), 32'h000);
`endif
        repeat (31) short_frame(1'b1);
        step(10'd5, 10'd7, 1'b1, HS_INACT, VS_INACT, 1'b0);
        idle();
        check("scroll32_rom_ad", 32'(rom_ad), 32'h0E5);
        short_frame(1'b1);
        step(10'd0, 10'd0, 1'b1, HS_INACT, VS_INACT, 1'b0);
        idle();
        check("scroll33_rom_ad", 32'(rom_ad), 32'h020);
        repeat (10) short_frame(1'b0);
        step(10'd0, 10'd0, 1'b1, HS_INACT, VS_INACT, 1'b0);
        idle();
        check("scroll_hold_rom_ad", 32'(rom_ad), 32'h020);

        // Randomized frames with a reset landing mid-frame.
        for (int f = 0; f < 160; f++) begin
            if (f == 70) do_reset();
            random_frame();
        end

        repeat (4) @(negedge clk);
        #1;
        check("ad_queue_drained", 32'(ad_q.size()), 32'd0);
        check("out_queue_drained", 32'(out_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
